// File: rtl/keylock_core.sv
// keylock_core: keypad lock controller with user/master codes,
// code change, failed-attempt lockout and inactivity timeout.
//
// Ports:
//   hwclk, reset       - clock, synchronous active-high reset
//   key, key_valid     - debounced key code and its one-cycle strobe
//   locked, lockout    - lock state, high while locked out
//   prog_mode          - high while entering/confirming a new code
//   digit_count        - digits in entry buffer (DIGITS+1 = overlength)
//   success, error     - one-cycle result pulses
//   user_code          - current user code
module keylock_core #(
    parameter int                  DIGITS         = 6,
    parameter logic [4*DIGITS-1:0] MASTER_CODE    = 24'h555116,
    parameter logic [4*DIGITS-1:0] DEFAULT_UC     = 24'h666666,
    parameter int                  MAX_FAILS      = 3,
    parameter int                  LOCKOUT_CYCLES = 120000000,
    parameter int                  TIMEOUT_CYCLES = 60000000
) (
    input  logic                        hwclk,
    input  logic                        reset,
    input  logic [3:0]                  key,
    input  logic                        key_valid,
    output logic                        locked,
    output logic                        lockout,
    output logic                        prog_mode,
    output logic [$clog2(DIGITS+2)-1:0] digit_count,
    output logic                        success,
    output logic                        error,
    output logic [4*DIGITS-1:0]         user_code
);

    localparam int CW   = 4 * DIGITS;
    localparam int DCW  = $clog2(DIGITS + 2);
    localparam int TMAX = (LOCKOUT_CYCLES > TIMEOUT_CYCLES) ?
                          LOCKOUT_CYCLES : TIMEOUT_CYCLES;
    localparam int TW   = $clog2(TMAX + 1);
    localparam int FW   = $clog2(MAX_FAILS + 1);

    localparam logic [DCW-1:0] DC_FULL = DCW'(DIGITS);
    localparam logic [DCW-1:0] DC_OVER = DCW'(DIGITS + 1);
    localparam logic [TW-1:0]  T_LOCK  = TW'(LOCKOUT_CYCLES - 1);
    localparam logic [TW-1:0]  T_IDLE  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [FW-1:0]  F_LAST  = FW'(MAX_FAILS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ENTRY,
        S_NEW,
        S_CONFIRM,
        S_LOCK
    } state_t;

    state_t          state;
    logic [CW-1:0]   entry_buf;
    logic [CW-1:0]   pending;
    logic [TW-1:0]   timer;
    logic [FW-1:0]   fail_cnt;

    logic is_dig;
    logic is_clr;
    logic is_ent;
    logic valid;

    assign is_dig = key_valid && (key <= 4'd9);
    assign is_clr = key_valid && (key == 4'hA);
    assign is_ent = key_valid && (key == 4'hB);
    assign valid  = (digit_count == DC_FULL);

    always_ff @(posedge hwclk) begin
        if (reset) begin
            state       <= S_IDLE;
            locked      <= 1'b0;
            lockout     <= 1'b0;
            prog_mode   <= 1'b0;
            success     <= 1'b0;
            error       <= 1'b0;
            digit_count <= '0;
            entry_buf   <= '0;
            pending     <= '0;
            timer       <= '0;
            fail_cnt    <= '0;
            user_code   <= DEFAULT_UC;
        end else begin
            success <= 1'b0;
            error   <= 1'b0;
            case (state)
                S_LOCK: begin
                    // Keys are dropped for the whole lockout window,
                    // including its final cycle.
                    entry_buf   <= '0;
                    digit_count <= '0;
                    if (timer == '0) begin
                        state   <= S_IDLE;
                        lockout <= 1'b0;
                    end else begin
                        timer <= timer - 1'b1;
                    end
                end
                default: begin
                    if (is_dig) begin
                        entry_buf <= {entry_buf[CW-5:0], key};
                        if (digit_count != DC_OVER)
                            digit_count <= digit_count + 1'b1;
                        timer <= '0;
                        if (state == S_IDLE)
                            state <= S_ENTRY;
                    end else if (is_clr) begin
                        entry_buf   <= '0;
                        digit_count <= '0;
                        timer       <= '0;
                        if (state == S_ENTRY)
                            state <= S_IDLE;
                    end else if (is_ent) begin
                        entry_buf   <= '0;
                        digit_count <= '0;
                        timer       <= '0;
                        case (state)
                            S_IDLE, S_ENTRY: begin
                                if (valid && entry_buf == MASTER_CODE) begin
                                    state     <= S_NEW;
                                    prog_mode <= 1'b1;
                                    fail_cnt  <= '0;
                                end else if (valid &&
                                             entry_buf == user_code) begin
                                    locked   <= ~locked;
                                    success  <= 1'b1;
                                    fail_cnt <= '0;
                                    state    <= S_IDLE;
                                end else begin
                                    error <= 1'b1;
                                    if (fail_cnt == F_LAST) begin
                                        state    <= S_LOCK;
                                        lockout  <= 1'b1;
                                        fail_cnt <= '0;
                                        timer    <= T_LOCK;
                                    end else begin
                                        fail_cnt <= fail_cnt + 1'b1;
                                        state    <= S_IDLE;
                                    end
                                end
                            end
                            S_NEW: begin
                                if (valid) begin
                                    pending <= entry_buf;
                                    state   <= S_CONFIRM;
                                end else begin
                                    error     <= 1'b1;
                                    prog_mode <= 1'b0;
                                    state     <= S_IDLE;
                                end
                            end
                            S_CONFIRM: begin
                                if (valid && entry_buf == pending) begin
                                    user_code <= pending;
                                    success   <= 1'b1;
                                end else begin
                                    error <= 1'b1;
                                end
                                prog_mode <= 1'b0;
                                state     <= S_IDLE;
                            end
                            default: ;
                        endcase
                    end else if (state != S_IDLE) begin
                        // Inactivity timer only runs while an entry
                        // or a code change is in progress.
                        if (timer == T_IDLE) begin
                            error       <= 1'b1;
                            entry_buf   <= '0;
                            digit_count <= '0;
                            pending     <= '0;
                            timer       <= '0;
                            prog_mode   <= 1'b0;
                            state       <= S_IDLE;
                        end else begin
                            timer <= timer + 1'b1;
                        end
                    end
                end
            endcase
        end
    end

endmodule
